// File: rtl/linear_net_pkg.sv
// Shared helpers for linearNet constant-weight layers: accumulator sizing,
// packed-weight extraction and signed saturation.
package linear_net_pkg;

    localparam int unsigned SAT_MAX_W    = 128;
    localparam int unsigned WGT_MAX_BITS = 1024;
    localparam int unsigned WGT_IDX_W    = $clog2(WGT_MAX_BITS);

    typedef logic signed [31:0] weight_t;

    // data sits above sat so a narrow size-cast keeps {data[OUT_WIDTH-1:0], sat}
    typedef struct packed {
        logic signed [SAT_MAX_W-1:0] data;
        logic                        sat;
    } sat_res_t;

    function automatic int unsigned acc_width(input int unsigned width,
                                              input int unsigned w_width,
                                              input int unsigned n_ch);
        return width + w_width + int'($clog2(n_ch)) + 1;
    endfunction

    function automatic weight_t get_weight(input logic [WGT_MAX_BITS-1:0] weights,
                                           input int unsigned w_width,
                                           input int unsigned k);
        weight_t w;
        w = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < w_width) w[i] = weights[WGT_IDX_W'(k * w_width + i)];
            else             w[i] = weights[WGT_IDX_W'(k * w_width + w_width - 1)];
        end
        return w;
    endfunction

    function automatic sat_res_t sat_signed(input logic signed [SAT_MAX_W-1:0] value,
                                            input int unsigned out_w);
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        sat_res_t r;
        hi     = SAT_MAX_W'(1);
        hi     = (hi <<< (out_w - 1)) - SAT_MAX_W'(1);
        lo     = ~hi;
        r.sat  = 1'b0;
        r.data = value;
        if (value > hi) begin
            r.sat  = 1'b1;
            r.data = hi;
        end else if (value < lo) begin
            r.sat  = 1'b1;
            r.data = lo;
        end
        return r;
    endfunction

endpackage

// File: rtl/const_dot_pipe_term.sv
// One channel's signed product against a compile-time weight, built as
// shift-add of |WEIGHT| with a final negation so the input minimum stays exact.
module const_term #(
    parameter int unsigned                WIDTH   = 16,
    parameter int unsigned                W_WIDTH = 8,
    parameter logic signed [W_WIDTH-1:0]  WEIGHT  = '0
) (
    input  logic [WIDTH-1:0]         data_i,
    output logic [WIDTH+W_WIDTH-1:0] prod_o
);

    localparam int unsigned          PROD_W = WIDTH + W_WIDTH;
    localparam logic                 W_NEG  = WEIGHT[W_WIDTH-1];
    localparam logic [W_WIDTH-1:0]   W_MAG  = W_NEG ? W_WIDTH'(-WEIGHT) : W_WIDTH'(WEIGHT);

    logic signed [PROD_W-1:0] in_ext;
    logic signed [PROD_W-1:0] mag_prod;

    always_comb begin
        in_ext   = PROD_W'($signed(data_i));
        mag_prod = '0;
        for (int unsigned j = 0; j < W_WIDTH; j++) begin
            if (W_MAG[j]) mag_prod = mag_prod + (in_ext <<< j);
        end
        prod_o = W_NEG ? -mag_prod : mag_prod;
    end

endmodule

// File: rtl/const_dot_pipe.sv
// Three-stage elastic constant-weight dot product: products, sum, bias+saturate.
// Each stage advances when the stage ahead is empty or itself advancing.
module const_dot_pipe
    import linear_net_pkg::*;
#(
    parameter int unsigned             N_CH      = 4,
    parameter int unsigned             WIDTH     = 16,
    parameter int unsigned             W_WIDTH   = 8,
    parameter logic [N_CH*W_WIDTH-1:0] WEIGHTS   = '0,
    parameter int                      BIAS      = 0,
    parameter int unsigned             OUT_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH*WIDTH-1:0]   in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [OUT_WIDTH-1:0]    out_data,
    output logic                    out_sat,
    output logic                    out_valid,
    input  logic                    out_ready
);

    localparam int unsigned PROD_W = WIDTH + W_WIDTH;
    localparam int unsigned ACC_W  = acc_width(WIDTH, W_WIDTH, N_CH);
    localparam int unsigned SUM_W  = ACC_W + 1;

    logic [N_CH-1:0][PROD_W-1:0] prod_c;
    logic [N_CH-1:0][PROD_W-1:0] prod_q, prod_d;
    logic                        s1_v_q, s1_v_d;
    logic                        s2_v_q, s2_v_d;
    logic signed [ACC_W-1:0]     acc_q, acc_d, acc_sum;
    logic signed [SUM_W-1:0]     biased;
    logic                        out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;
    logic [OUT_WIDTH-1:0]        sat_data_c;
    logic                        sat_c;
    logic                        adv1, adv2, adv3;

    for (genvar k = 0; k < N_CH; k++) begin : g_term
        localparam weight_t WK = get_weight(WGT_MAX_BITS'(WEIGHTS), W_WIDTH, k);
        const_term #(
            .WIDTH   (WIDTH),
            .W_WIDTH (W_WIDTH),
            .WEIGHT  (W_WIDTH'(WK))
        ) u_term (
            .data_i (in_data[k*WIDTH +: WIDTH]),
            .prod_o (prod_c[k])
        );
    end

    assign adv3     = !out_valid_q || out_ready;
    assign adv2     = !out_valid_q || adv3;
    assign adv1     = !s2_v_q || adv2;
    assign in_ready = !s1_v_q || adv1;

    always_comb begin
        acc_sum = '0;
        for (int unsigned k = 0; k < N_CH; k++) begin
            acc_sum = acc_sum + ACC_W'($signed(prod_q[k]));
        end
        biased = SUM_W'(acc_q) + SUM_W'(BIAS);
    end

    // A sum that cannot exceed the output range needs no clipping logic
    if (OUT_WIDTH >= SUM_W) begin : g_nosat
        assign sat_c      = 1'b0;
        assign sat_data_c = OUT_WIDTH'(biased);
    end else begin : g_sat
        assign {sat_data_c, sat_c} = (OUT_WIDTH + 1)'(sat_signed(SAT_MAX_W'(biased), OUT_WIDTH));
    end

    always_comb begin
        s1_v_d      = s1_v_q;
        prod_d      = prod_q;
        s2_v_d      = s2_v_q;
        acc_d       = acc_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        if (in_ready) begin
            s1_v_d = in_valid;
            if (in_valid) prod_d = prod_c;
        end
        if (adv1) begin
            s2_v_d = s1_v_q;
            if (s1_v_q) acc_d = acc_sum;
        end
        if (adv3) begin
            out_valid_d = s2_v_q;
            if (s2_v_q) begin
                out_data_d = sat_data_c;
                out_sat_d  = sat_c;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q      <= 1'b0;
            prod_q      <= '0;
            s2_v_q      <= 1'b0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            s1_v_q      <= s1_v_d;
            prod_q      <= prod_d;
            s2_v_q      <= s2_v_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_const_dot_pipe.sv
// Directed bench for const_dot_pipe: three weight/width configurations,
// latency, exact min-value products, saturation, backpressure and mid-stream reset.
module tb_const_dot_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // A: W={1,-2,3,0}, BIAS=5
    logic [63:0] a_in_data;
    logic        a_in_valid, a_in_ready, a_out_sat, a_out_valid, a_out_ready;
    logic [31:0] a_out_data;
    // B: W={-1,-128,127,0}, BIAS=0
    logic [63:0] b_in_data;
    logic        b_in_valid, b_in_ready, b_out_sat, b_out_valid, b_out_ready;
    logic [31:0] b_out_data;
    // C: W all 127, OUT_WIDTH=16
    logic [63:0] c_in_data;
    logic        c_in_valid, c_in_ready, c_out_sat, c_out_valid, c_out_ready;
    logic [15:0] c_out_data;

    const_dot_pipe #(.N_CH(4), .WIDTH(16), .W_WIDTH(8), .WEIGHTS(32'h0003FE01),
                     .BIAS(5), .OUT_WIDTH(32)) u_a (
        .clk(clk), .rst_n(rst_n), .in_data(a_in_data), .in_valid(a_in_valid),
        .in_ready(a_in_ready), .out_data(a_out_data), .out_sat(a_out_sat),
        .out_valid(a_out_valid), .out_ready(a_out_ready));

    const_dot_pipe #(.N_CH(4), .WIDTH(16), .W_WIDTH(8), .WEIGHTS(32'h007F80FF),
                     .BIAS(0), .OUT_WIDTH(32)) u_b (
        .clk(clk), .rst_n(rst_n), .in_data(b_in_data), .in_valid(b_in_valid),
        .in_ready(b_in_ready), .out_data(b_out_data), .out_sat(b_out_sat),
        .out_valid(b_out_valid), .out_ready(b_out_ready));

    const_dot_pipe #(.N_CH(4), .WIDTH(16), .W_WIDTH(8), .WEIGHTS(32'h7F7F7F7F),
                     .BIAS(0), .OUT_WIDTH(16)) u_c (
        .clk(clk), .rst_n(rst_n), .in_data(c_in_data), .in_valid(c_in_valid),
        .in_ready(c_in_ready), .out_data(c_out_data), .out_sat(c_out_sat),
        .out_valid(c_out_valid), .out_ready(c_out_ready));

    function automatic logic [63:0] pack4(input int v0, input int v1, input int v2, input int v3);
        return {16'(v3), 16'(v2), 16'(v1), 16'(v0)};
    endfunction

    task automatic check(input string tag, input logic signed [63:0] obs, input longint exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic run_b(input string tag, input logic [63:0] din, input longint exp);
        @(negedge clk);
        b_in_data  = din;
        b_in_valid = 1'b1;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(b_out_valid), 1);
        check(tag, 64'($signed(b_out_data)), exp);
        check({tag, "_sat"}, 64'(b_out_sat), 0);
    endtask

    task automatic run_c(input string tag, input logic [63:0] din, input longint exp, input longint exp_sat);
        @(negedge clk);
        c_in_data  = din;
        c_in_valid = 1'b1;
        @(posedge clk); #1;
        c_in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(c_out_valid), 1);
        check(tag, 64'($signed(c_out_data)), exp);
        check({tag, "_sat"}, 64'(c_out_sat), exp_sat);
    endtask

    initial begin
        int          sent;
        int          rcvd;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        saw_block;

        rst_n = 1'b0;
        a_in_data = '0; a_in_valid = 1'b0; a_out_ready = 1'b1;
        b_in_data = '0; b_in_valid = 1'b0; b_out_ready = 1'b1;
        c_in_data = '0; c_in_valid = 1'b0; c_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 64'(a_out_valid), 0);
        check("rst_out_data", 64'(a_out_data), 0);
        check("rst_out_sat", 64'(a_out_sat), 0);
        check("rst_in_ready", 64'(a_in_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // basic dot product and three-cycle latency
        @(negedge clk);
        a_in_data  = pack4(10, 10, 10, 10);
        a_in_valid = 1'b1;
        #1 check("t1_in_ready", 64'(a_in_ready), 1);
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("t1_lat_c1", 64'(a_out_valid), 0);
        @(posedge clk); #1;
        check("t1_lat_c2", 64'(a_out_valid), 0);
        @(posedge clk); #1;
        check("t1_lat_c3", 64'(a_out_valid), 1);
        check("t1_data", 64'($signed(a_out_data)), 25);
        check("t1_sat", 64'(a_out_sat), 0);

        // exact products at the input minimum, including the weight minimum
        run_b("t2_w_neg1", pack4(-32768, 0, 0, 0), 32768);
        run_b("t2_w_m128", pack4(0, -32768, 0, 0), 4194304);
        run_b("t2_w_p127", pack4(0, 0, -32768, 0), -4161536);
        run_b("t2_all_min", pack4(-32768, -32768, -32768, -32768), 65536);
        run_b("t2_w_zero", pack4(5, 0, 0, 12345), -5);

        // saturation at both rails and just inside them
        run_c("t3_pos_sat", pack4(32767, 32767, 32767, 32767), 32767, 1);
        run_c("t3_neg_sat", pack4(-32768, -32768, -32768, -32768), -32768, 1);
        run_c("t3_hi_in", pack4(258, 0, 0, 0), 32766, 0);
        run_c("t3_hi_over", pack4(259, 0, 0, 0), 32767, 1);
        run_c("t3_lo_in", pack4(-258, 0, 0, 0), -32766, 0);
        run_c("t3_lo_over", pack4(-259, 0, 0, 0), -32768, 1);
        run_c("t3_small", pack4(-1, -1, -1, -1), -508, 0);

        // 8 back-to-back beats with out_ready toggling 1,0,1,0...
        sent = 0; rcvd = 0; prev_stall = 1'b0; prev_data = '0; saw_block = 1'b0;
        for (int cyc = 0; cyc < 60 && rcvd < 8; cyc++) begin
            @(negedge clk);
            a_out_ready = (cyc % 2 == 0);
            a_in_valid  = (sent < 8);
            a_in_data   = pack4(sent + 1, -(sent + 1), 100 * (sent + 1), 7);
            #1;
            if (prev_stall) begin
                check("t4_hold_valid", 64'(a_out_valid), 1);
                check("t4_hold_data", 64'(a_out_data), longint'(prev_data));
            end
            check("t4_in_ready", 64'(a_in_ready), ((sent - rcvd) < 3 || a_out_ready) ? 1 : 0);
            if (!a_in_ready) saw_block = 1'b1;
            if (a_out_valid && a_out_ready) begin
                check("t4_data", 64'($signed(a_out_data)), 303 * (rcvd + 1) + 5);
                rcvd++;
            end
            if (a_in_valid && a_in_ready) sent++;
            prev_stall = a_out_valid && !a_out_ready;
            prev_data  = a_out_data;
        end
        check("t4_count", 64'(rcvd), 8);
        check("t4_backpressure_seen", 64'(saw_block), 1);
        @(negedge clk);
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1 check("t4_no_extra", 64'(a_out_valid), 0);

        // fill all stages under stall, then reset mid-stream
        @(negedge clk);
        a_out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a_in_data  = pack4(50 + i, 0, 0, 0);
            a_in_valid = 1'b1;
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("t5_full_valid", 64'(a_out_valid), 1);
        check("t5_full_in_ready", 64'(a_in_ready), 0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_valid", 64'(a_out_valid), 0);
        check("t5_async_data", 64'(a_out_data), 0);
        check("t5_async_in_ready", 64'(a_in_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n       = 1'b1;
        a_out_ready = 1'b1;
        @(negedge clk);
        a_in_data  = pack4(20, -20, 2000, 7);
        a_in_valid = 1'b1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        check("t5_post_c1", 64'(a_out_valid), 0);
        @(posedge clk); #1;
        check("t5_post_c2", 64'(a_out_valid), 0);
        @(posedge clk); #1;
        check("t5_post_valid", 64'(a_out_valid), 1);
        check("t5_post_data", 64'($signed(a_out_data)), 6065);

        // full throughput with out_ready held high
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            c_in_valid = (k < 4);
            c_in_data  = pack4(k + 1, 0, 0, 0);
            #1;
            if (k < 4) check("t6_in_ready", 64'(c_in_ready), 1);
            if (k >= 3) begin
                check("t6_valid", 64'(c_out_valid), 1);
                check("t6_data", 64'($signed(c_out_data)), 127 * (k - 2));
            end
        end
        c_in_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_drained", 64'(c_out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
